// File: rtl/icache_axi_refill_pkg.sv
// icache_axi_refill_pkg: shared types and AXI constants for the ICache line refill path.
package icache_axi_refill_pkg;
    typedef enum logic [1:0] {IDLE, AR, R, RET} refill_state_t;
    localparam int ICACHE_LINE_WORDS = 8;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    typedef logic [ICACHE_LINE_WORDS*32-1:0] bus256_t;
    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction
endpackage

// File: rtl/icache_axi_refill_if.sv
// icache_axi_refill_if: ICache line request/return bus and the AXI read (AR/R) channel bundle.
interface icache_mem_if;
    import icache_axi_refill_pkg::*;
    logic rd_req;
    logic [31:0] rd_addr;
    logic ret_valid;
    bus256_t ret_data;
    logic ret_err;
    logic busy;
    modport master(output rd_req, rd_addr, input ret_valid, ret_data, ret_err, busy);
    modport slave(input rd_req, rd_addr, output ret_valid, ret_data, ret_err, busy);
endinterface

interface axi_rd_if;
    logic arvalid;
    logic arready;
    logic [31:0] araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic [3:0] arid;
    logic rvalid;
    logic rready;
    logic [31:0] rdata;
    logic [1:0] rresp;
    logic rlast;
    modport master(output arvalid, araddr, arlen, arsize, arburst, arid, rready,
                   input arready, rvalid, rdata, rresp, rlast);
    modport slave(input arvalid, araddr, arlen, arsize, arburst, arid, rready,
                  output arready, rvalid, rdata, rresp, rlast);
endinterface

// File: rtl/icache_axi_refill.sv
// icache_axi_refill: turns one ICache line request into an 8-beat AXI INCR read and returns the assembled line.
module icache_axi_refill
    import icache_axi_refill_pkg::*;
#(
    parameter int LINE_WORDS = ICACHE_LINE_WORDS,
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input logic clk,
    input logic rst_n,
    icache_mem_if.slave icache,
    axi_rd_if.master axi
);
    localparam logic [2:0] LAST = 3'(LINE_WORDS - 1);

    refill_state_t r_state, w_next;
    logic [31:0] r_araddr;
    logic r_arvalid, r_rready, r_ret_valid, r_err, r_busy;
    bus256_t r_data;
    logic [2:0] r_cnt;
    logic w_ar_hs, w_r_hs, w_end, w_unused;

    assign w_ar_hs = r_arvalid && axi.arready;
    assign w_r_hs = r_rready && axi.rvalid;
    assign w_end = w_r_hs && (axi.rlast || r_cnt == LAST);
    assign w_unused = ^icache.rd_addr[4:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = icache.rd_req ? AR : IDLE;
            AR: w_next = w_ar_hs ? R : AR;
            R: w_next = w_end ? RET : R;
            default: w_next = IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they are registered yet cycle-exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_arvalid <= 1'b0;
            r_rready <= 1'b0;
            r_ret_valid <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_state <= w_next;
            r_arvalid <= w_next == AR;
            r_rready <= w_next == R;
            r_ret_valid <= w_next == RET;
            r_busy <= w_next != IDLE;
        end
    end

    // A beat is malformed when rlast disagrees with the beat index; errors stay sticky until the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_araddr <= '0;
            r_data <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            if (r_state == IDLE && icache.rd_req) begin
                r_araddr <= line_addr(icache.rd_addr);
                r_data <= '0;
                r_err <= 1'b0;
                r_cnt <= '0;
            end
            if (w_ar_hs) r_cnt <= '0;
            if (w_r_hs) begin
                r_data[{r_cnt, 5'd0} +: 32] <= axi.rdata;
                r_cnt <= r_cnt + 3'd1;
                if (axi.rresp != AXI_RESP_OKAY || axi.rlast != (r_cnt == LAST)) r_err <= 1'b1;
            end
        end
    end

    assign icache.ret_valid = r_ret_valid;
    assign icache.ret_data = r_data;
    assign icache.ret_err = r_err;
    assign icache.busy = r_busy;
    assign axi.arvalid = r_arvalid;
    assign axi.araddr = r_araddr;
    assign axi.arlen = 8'(LINE_WORDS - 1);
    assign axi.arsize = AXI_SIZE_4B;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arid = AXI_ID;
    assign axi.rready = r_rready;
endmodule

// File: tb/tb_icache_axi_refill.sv
// tb_icache_axi_refill: directed checks of the ICache AXI line refill responder.
module tb_icache_axi_refill;
    import icache_axi_refill_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0, bad = 0, ar_hs = 0, ret_cnt = 0;
    int ar0, rc0;
    logic [31:0] w [8];

    icache_mem_if icache();
    axi_rd_if axi();

    icache_axi_refill dut (.clk(clk), .rst_n(rst_n), .icache(icache), .axi(axi));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (axi.arvalid && axi.arready) ar_hs <= ar_hs + 1;
        if (icache.ret_valid) ret_cnt <= ret_cnt + 1;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bus256_t mk_line(input int n);
        bus256_t l = '0;
        for (int i = 0; i < n; i++) l[i*32 +: 32] = w[i];
        return l;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
        bit ok = 0;
        axi.rvalid = 1'b1;
        axi.rdata = d;
        axi.rresp = resp;
        axi.rlast = last;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (axi.rready) ok = 1;
            tick();
        end
        if (!ok) check("rbeat_timeout", 0, 1);
        axi.rvalid = 1'b0;
        axi.rlast = 1'b0;
        axi.rresp = 2'b00;
    endtask

    task automatic fetch(input logic [31:0] addr, input int gap, input int err_idx, input int last_idx);
        bit ok = 0;
        icache.rd_req = 1'b1;
        icache.rd_addr = addr;
        for (int k = 0; k < 64 && !ok; k++) begin
            if (axi.arvalid && axi.arready) begin
                check("araddr", axi.araddr, addr & ~32'h1f);
                ok = 1;
            end
            tick();
        end
        if (!ok) check("ar_timeout", 0, 1);
        for (int i = 0; i <= last_idx; i++) begin
            if (i > 0) repeat (gap) tick();
            send_beat(w[i], i == err_idx ? 2'b10 : 2'b00, i == last_idx);
        end
    endtask

    initial begin
        icache.rd_req = 0; icache.rd_addr = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
        tick(); tick();
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_ret_valid", icache.ret_valid, 0);
        check("rst_busy", icache.busy, 0);
        check("rst_araddr", axi.araddr, 0);
        check("rst_ret_data", icache.ret_data, 0);
        rst_n = 1'b1;
        tick();

        // basic fetch with exact latency
        for (int i = 0; i < 8; i++) w[i] = 32'h1111_1111 * (i + 1);
        axi.arready = 1;
        icache.rd_req = 1; icache.rd_addr = 32'h1C00_0014;
        tick();
        check("t1_arvalid", axi.arvalid, 1);
        check("t1_busy", icache.busy, 1);
        check("t1_araddr", axi.araddr, 32'h1C00_0000);
        check("t1_arlen", axi.arlen, 7);
        check("t1_arsize", axi.arsize, 2);
        check("t1_arburst", axi.arburst, 1);
        check("t1_arid", axi.arid, 0);
        tick();
        check("t1_rready", axi.rready, 1);
        check("t1_arvalid_drop", axi.arvalid, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("t1_no_early_ret", icache.ret_valid, 0);
            send_beat(w[i], 2'b00, i == 7);
        end
        check("t1_ret_valid", icache.ret_valid, 1);
        check("t1_ret_err", icache.ret_err, 0);
        check("t1_ret_data", icache.ret_data, mk_line(8));
        icache.rd_req = 0;
        tick();
        check("t1_ret_pulse", icache.ret_valid, 0);
        check("t1_idle", icache.busy, 0);
        check("t1_data_hold", icache.ret_data, mk_line(8));

        // AR and R backpressure
        for (int i = 0; i < 8; i++) w[i] = 32'hA000_0000 + i;
        rc0 = ret_cnt;
        axi.arready = 0;
        icache.rd_req = 1; icache.rd_addr = 32'h8000_1234;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("t2_arvalid_hold", axi.arvalid, 1);
            check("t2_araddr_hold", axi.araddr, 32'h8000_1220);
            tick();
        end
        axi.arready = 1;
        check("t2_arvalid_6th", axi.arvalid, 1);
        tick();
        check("t2_arvalid_done", axi.arvalid, 0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin tick(); tick(); end
            send_beat(w[i], 2'b00, i == 7);
        end
        check("t2_ret_valid", icache.ret_valid, 1);
        check("t2_ret_data", icache.ret_data, mk_line(8));
        check("t2_ret_err", icache.ret_err, 0);
        icache.rd_req = 0;
        repeat (3) tick();
        check("t2_ret_once", ret_cnt - rc0, 1);

        // error response on one beat
        for (int i = 0; i < 8; i++) w[i] = 32'hC0DE_0000 | (32'(i) << 4);
        fetch(32'h0000_4040, 0, 3, 7);
        check("t3_ret_valid", icache.ret_valid, 1);
        check("t3_ret_err", icache.ret_err, 1);
        check("t3_ret_data", icache.ret_data, mk_line(8));
        icache.rd_req = 0;
        tick();

        // short burst: rlast on beat 4
        for (int i = 0; i < 8; i++) w[i] = 32'h5A5A_0000 + 32'(i * 3 + 1);
        fetch(32'h1234_56FF, 1, -1, 3);
        check("t4_ret_valid", icache.ret_valid, 1);
        check("t4_ret_err", icache.ret_err, 1);
        check("t4_ret_data", icache.ret_data, mk_line(4));
        check("t4_rready_off", axi.rready, 0);
        icache.rd_req = 0;
        tick();
        check("t4_rready_idle", axi.rready, 0);

        // back-to-back requests, rd_req held through ret_valid
        ar0 = ar_hs; rc0 = ret_cnt;
        for (int i = 0; i < 8; i++) w[i] = 32'hB000_0000 + i;
        fetch(32'h0000_0100, 0, -1, 7);
        check("t5_ret1", icache.ret_valid, 1);
        tick();
        icache.rd_req = 0;
        check("t5_idle", icache.busy, 0);
        tick();
        for (int i = 0; i < 8; i++) w[i] = 32'hD000_0000 + i;
        fetch(32'h0000_0220, 0, -1, 7);
        check("t5_ret2", icache.ret_valid, 1);
        check("t5_data2", icache.ret_data, mk_line(8));
        icache.rd_req = 0;
        repeat (4) tick();
        check("t5_ar_count", ar_hs - ar0, 2);
        check("t5_ret_count", ret_cnt - rc0, 2);

        // asynchronous reset mid-burst, then a clean fetch
        for (int i = 0; i < 8; i++) w[i] = 32'hE000_0000 + i;
        fetch(32'h0F00_0000, 0, -1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_arvalid", axi.arvalid, 0);
        check("t6_rready", axi.rready, 0);
        check("t6_busy", icache.busy, 0);
        check("t6_ret_valid", icache.ret_valid, 0);
        check("t6_araddr", axi.araddr, 0);
        check("t6_ret_data", icache.ret_data, 0);
        icache.rd_req = 0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) w[i] = 32'h7700_0000 + 32'(i * 17);
        fetch(32'hFFFF_FFE4, 0, -1, 7);
        check("t6_ret_valid_new", icache.ret_valid, 1);
        check("t6_ret_err_new", icache.ret_err, 0);
        check("t6_ret_data_new", icache.ret_data, mk_line(8));
        icache.rd_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache_axi_refill.md
Name: icache_axi_refill

Overview:
Memory-side responder (slave end) of the icache_mem interface. Accepts a single cache-line read request from the ICache (rd_req/rd_addr) and issues one 8-beat AXI4 INCR read burst. Assembles the returned 32-bit beats into a 256-bit line and hands it back via ret_valid/ret_data. Sits between the ICache and the AXI crossbar/arbiter; one outstanding request at a time.

Parameters:
LINE_WORDS, 8, 32-bit words per line; fixes arlen = LINE_WORDS-1
AXI_ID, 4'h0, constant arid driven on every request

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_req  in  1  icache_mem read request; held by ICache until it sees ret_valid
rd_addr  in  32  physical line address; low 5 bits ignored
ret_valid  out  1  one-cycle pulse: ret_data holds the complete line
ret_data  out  256  returned line; word i at [32i+31:32i], word 0 = lowest address
ret_err  out  1  valid with ret_valid; line had a bad response or malformed burst
busy  out  1  state != IDLE
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
araddr  out  32  {rd_addr[31:5], 5'b0}
arlen  out  8  LINE_WORDS-1 (8'd7)
arsize  out  3  3'b010 (4 bytes)
arburst  out  2  2'b01 (INCR)
arid  out  4  AXI_ID
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready
rdata  in  32  AXI R data
rresp  in  2  AXI R response
rlast  in  1  AXI R last

Behaviour:
- Reset (rst_n=0, async): state IDLE; arvalid, rready, ret_valid, ret_err = 0; ret_data, araddr, beat counter = 0. Reset mid-burst abandons the burst; the interconnect shares rst_n, so no stray beats are expected.
- States: IDLE, AR, R, RET.
- IDLE: rd_req=1 -> latch {rd_addr[31:5],5'b0} into araddr, clear line buffer/err/counter, go AR. rd_req=0 -> stay.
- AR: arvalid=1 and AR fields stable. arvalid&&arready -> go R, cnt=0. arvalid stays high until the handshake (no AXI retraction).
- R: rready=1. On each rvalid&&rready, word[cnt] <= rdata, cnt++. If rresp != 2'b00, set err (sticky).
  - Normal end: rlast with cnt==7 -> RET.
  - rlast with cnt<7 -> set err, RET; remaining words keep 0.
  - cnt==7 beat without rlast -> set err, RET. Further beats are not accepted because rready=0 outside R.
- RET: ret_valid=1 for exactly one cycle with ret_data/ret_err, then go IDLE. ret_data stays stable until the next request is accepted.
- rd_req is only sampled in IDLE. A registered ICache sees ret_valid at the RET edge and drops rd_req, so rd_req=0 in the following IDLE cycle and there is no double fetch. rd_req still high in IDLE starts a new fetch.
- rd_addr changing while busy: ignored; the latched address is used.
- Latency with arready=1 and back-to-back beats:
  - rd_req in IDLE at cycle 0.
  - arvalid at cycle 1.
  - beats at cycles 2..9.
  - ret_valid at cycle 10.
- All outputs are registered; there is no combinational path from AXI inputs to AXI outputs.

Decomposition:
- Shared package (pipeline_types): refill_state_t enum {IDLE, AR, R, RET}.
- Shared package constants: AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00, ICACHE_LINE_WORDS=8. Reuse the existing bus256_t.
- No sub-module: the line buffer is a 3-bit-indexed register write inside the block. Top-level wiring uses the icache_mem slave modport for rd_req/rd_addr/ret_valid/ret_data.

Test Plan:
- Basic fetch: rd_req, rd_addr=32'h1C00_0014, arready=1, beats 0x11111111..0x88888888 back-to-back with rlast on beat 8 -> araddr=32'h1C00_0000, arlen=7, arsize=2, arburst=1; ret_valid one cycle at cycle 10; ret_data[31:0]=0x11111111, ret_data[255:224]=0x88888888; ret_err=0.
- Backpressure: arready low 5 cycles, rvalid gaps of 2 cycles between beats -> arvalid held stable 6 cycles; line still assembled in order; ret_valid exactly once.
- Error response: rresp=2'b10 on beat 3 -> ret_err=1 with ret_valid; the other 7 words are correct.
- Short burst: rlast on beat 4 -> ret_valid after beat 4, ret_err=1, words 4..7=0; rready=0 afterwards.
- Back-to-back: rd_req held through ret_valid and dropped the next cycle, then re-asserted 1 cycle later with a new address -> exactly two AR handshakes, no duplicate fetch.
- Reset mid-burst: rst_n low after beat 2 -> all outputs 0 immediately (async); after release, a new rd_req completes normally.
